// File: rtl/nasti_lite_reg_port.sv
`default_nettype none
// ============================================================================
// Module   : nasti_lite_reg_port
// Purpose  : NASTI-Lite slave endpoint bridging lite read/write channels onto
//            a single-outstanding req/ack register bus, with timeout abort.
// Revision : 1.0
// ============================================================================
module nasti_lite_reg_port #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     lite_ar_id,
    input  logic [ADDR_WIDTH-1:0]   lite_ar_addr,
    input  logic [2:0]              lite_ar_prot,
    input  logic [3:0]              lite_ar_qos,
    input  logic [3:0]              lite_ar_region,
    input  logic [USER_WIDTH-1:0]   lite_ar_user,
    input  logic                    lite_ar_valid,
    output logic                    lite_ar_ready,
    output logic [ID_WIDTH-1:0]     lite_r_id,
    output logic [DATA_WIDTH-1:0]   lite_r_data,
    output logic [1:0]              lite_r_resp,
    output logic [USER_WIDTH-1:0]   lite_r_user,
    output logic                    lite_r_valid,
    input  logic                    lite_r_ready,
    input  logic [ID_WIDTH-1:0]     lite_aw_id,
    input  logic [ADDR_WIDTH-1:0]   lite_aw_addr,
    input  logic [2:0]              lite_aw_prot,
    input  logic [3:0]              lite_aw_qos,
    input  logic [3:0]              lite_aw_region,
    input  logic [USER_WIDTH-1:0]   lite_aw_user,
    input  logic                    lite_aw_valid,
    output logic                    lite_aw_ready,
    input  logic [DATA_WIDTH-1:0]   lite_w_data,
    input  logic [DATA_WIDTH/8-1:0] lite_w_strb,
    input  logic [USER_WIDTH-1:0]   lite_w_user,
    input  logic                    lite_w_valid,
    output logic                    lite_w_ready,
    output logic [ID_WIDTH-1:0]     lite_b_id,
    output logic [1:0]              lite_b_resp,
    output logic [USER_WIDTH-1:0]   lite_b_user,
    output logic                    lite_b_valid,
    input  logic                    lite_b_ready,
    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_be,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ALIGN_BITS = $clog2(STRB_WIDTH);
    localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_WR_REQ  = 3'd2,
        S_RD_RESP = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    prio_wr_q, prio_wr_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    rd_cand, wr_cand, take_rd, take_wr;

    logic unused_inputs;
    assign unused_inputs = ^{lite_ar_prot, lite_ar_qos, lite_ar_region,
                             lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user};

    always_comb begin
        state_d       = state_q;
        prio_wr_d     = prio_wr_q;
        cnt_d         = cnt_q;
        id_d          = id_q;
        user_d        = user_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        lite_ar_ready = 1'b0;
        lite_aw_ready = 1'b0;
        lite_w_ready  = 1'b0;
        // Gated by rstn so nothing is handshaken while the flops are held in reset.
        rd_cand       = rstn && lite_ar_valid;
        wr_cand       = rstn && lite_aw_valid && lite_w_valid;
        take_wr       = (state_q == S_IDLE) && wr_cand && (!rd_cand || prio_wr_q);
        take_rd       = (state_q == S_IDLE) && rd_cand && !take_wr;

        case (state_q)
            S_IDLE: begin
                if (take_rd) begin
                    lite_ar_ready = 1'b1;
                    id_d          = lite_ar_id;
                    user_d        = lite_ar_user;
                    addr_d        = lite_ar_addr & ADDR_MASK;
                    be_d          = '1;
                    prio_wr_d     = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_RD_REQ;
                end else if (take_wr) begin
                    lite_aw_ready = 1'b1;
                    lite_w_ready  = 1'b1;
                    id_d          = lite_aw_id;
                    user_d        = lite_aw_user;
                    addr_d        = lite_aw_addr & ADDR_MASK;
                    wdata_d       = lite_w_data;
                    be_d          = lite_w_strb;
                    prio_wr_d     = 1'b0;
                    cnt_d         = '0;
                    state_d       = S_WR_REQ;
                end
            end
            S_RD_REQ, S_WR_REQ: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (reg_ack) begin
                    resp_d = reg_err ? RESP_SLVERR : RESP_OKAY;
                    if (state_q == S_RD_REQ) begin
                        rdata_d = reg_rdata;
                        state_d = S_RD_RESP;
                    end else begin
                        state_d = S_WR_RESP;
                    end
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT)) begin
                    resp_d  = RESP_DECERR;
                    rdata_d = '0;
                    state_d = (state_q == S_RD_REQ) ? S_RD_RESP : S_WR_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_RD_RESP: if (lite_r_ready) state_d = S_IDLE;
            S_WR_RESP: if (lite_b_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            prio_wr_q <= 1'b0;
            cnt_q     <= '0;
            id_q      <= '0;
            user_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            user_q    <= user_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign reg_req      = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign reg_we       = (state_q == S_WR_REQ);
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;
    assign reg_be       = be_q;
    assign lite_r_valid = (state_q == S_RD_RESP);
    assign lite_r_id    = id_q;
    assign lite_r_user  = user_q;
    assign lite_r_data  = rdata_q;
    assign lite_r_resp  = resp_q;
    assign lite_b_valid = (state_q == S_WR_RESP);
    assign lite_b_id    = id_q;
    assign lite_b_user  = user_q;
    assign lite_b_resp  = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_nasti_lite_reg_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_nasti_lite_reg_port
// Purpose  : Vector table, corner-case sequences and randomized transactions
//            checked against a transaction-level model of the register port.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_nasti_lite_reg_port;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [0:0]  ar_id, aw_id, r_id, b_id;
    logic [11:0] ar_addr, aw_addr, reg_addr;
    logic [0:0]  ar_user, aw_user, w_user, r_user, b_user;
    logic        ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready;
    logic [31:0] r_data, w_data, reg_wdata, reg_rdata;
    logic [1:0]  r_resp, b_resp;
    logic        r_valid, r_ready, b_valid, b_ready;
    logic [3:0]  w_strb, reg_be;
    logic        reg_req, reg_we, reg_ack, reg_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nasti_lite_reg_port #(
        .ID_WIDTH(1), .ADDR_WIDTH(12), .DATA_WIDTH(32), .USER_WIDTH(1), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .lite_ar_id(ar_id), .lite_ar_addr(ar_addr), .lite_ar_prot(3'd0), .lite_ar_qos(4'd0),
        .lite_ar_region(4'd0), .lite_ar_user(ar_user), .lite_ar_valid(ar_valid), .lite_ar_ready(ar_ready),
        .lite_r_id(r_id), .lite_r_data(r_data), .lite_r_resp(r_resp), .lite_r_user(r_user),
        .lite_r_valid(r_valid), .lite_r_ready(r_ready),
        .lite_aw_id(aw_id), .lite_aw_addr(aw_addr), .lite_aw_prot(3'd0), .lite_aw_qos(4'd0),
        .lite_aw_region(4'd0), .lite_aw_user(aw_user), .lite_aw_valid(aw_valid), .lite_aw_ready(aw_ready),
        .lite_w_data(w_data), .lite_w_strb(w_strb), .lite_w_user(w_user), .lite_w_valid(w_valid),
        .lite_w_ready(w_ready),
        .lite_b_id(b_id), .lite_b_resp(b_resp), .lite_b_user(b_user), .lite_b_valid(b_valid),
        .lite_b_ready(b_ready),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_be(reg_be), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        id;
        logic        user;
        int          dly;     // REQ cycles before ack; beyond TMO means never
        bit          err;
        logic [31:0] rdata;
        int          hold;    // cycles response ready is held low
        logic [11:0] e_addr;
        logic [3:0]  e_be;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        int          e_cycles;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectations derived from the port's rules.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        bit   tmo = (v.dly > TMO);
        o.e_addr   = {v.addr[11:2], 2'b00};
        o.e_be     = v.wr ? v.strb : 4'hF;
        o.e_resp   = tmo ? 2'b11 : (v.err ? 2'b10 : 2'b00);
        o.e_data   = tmo ? 32'h0 : v.rdata;
        o.e_cycles = tmo ? TMO + 1 : v.dly + 1;
        return o;
    endfunction

    task automatic check_resp(input vec_t v, input string tag);
        if (v.wr) begin
            chk({tag, " b_valid"}, 64'(b_valid), 64'(1));
            chk({tag, " b_id"},    64'(b_id),    64'(v.id));
            chk({tag, " b_user"},  64'(b_user),  64'(v.user));
            chk({tag, " b_resp"},  64'(b_resp),  64'(v.e_resp));
        end else begin
            chk({tag, " r_valid"}, 64'(r_valid), 64'(1));
            chk({tag, " r_id"},    64'(r_id),    64'(v.id));
            chk({tag, " r_user"},  64'(r_user),  64'(v.user));
            chk({tag, " r_resp"},  64'(r_resp),  64'(v.e_resp));
            chk({tag, " r_data"},  64'(r_data),  64'(v.e_data));
        end
    endtask

    // Entered and left one time unit after a rising edge with the DUT idle.
    task automatic run_txn(input vec_t v, input string tag);
        int k;
        if (v.wr) begin
            aw_valid = 1; w_valid = 1; aw_addr = v.addr; w_data = v.data;
            w_strb = v.strb; aw_id = v.id; aw_user = v.user;
        end else begin
            ar_valid = 1; ar_addr = v.addr; ar_id = v.id; ar_user = v.user;
        end
        #1;
        chk({tag, " accept"}, 64'(v.wr ? (aw_ready & w_ready) : ar_ready), 64'(1));
        tick();
        ar_valid = 0; aw_valid = 0; w_valid = 0;
        chk({tag, " reg_req"},  64'(reg_req),  64'(1));
        chk({tag, " reg_we"},   64'(reg_we),   64'(v.wr));
        chk({tag, " reg_addr"}, 64'(reg_addr), 64'(v.e_addr));
        chk({tag, " reg_be"},   64'(reg_be),   64'(v.e_be));
        if (v.wr) chk({tag, " reg_wdata"}, 64'(reg_wdata), 64'(v.data));
        k = 0;
        while (1) begin
            reg_ack = (k == v.dly); reg_rdata = v.rdata; reg_err = v.err;
            tick();
            reg_ack = 0;
            k++;
            if (!reg_req) break;
            if (k > 40) break;
        end
        chk({tag, " req_cycles"}, 64'(k), 64'(v.e_cycles));
        check_resp(v, tag);
        for (int h = 0; h < v.hold; h++) begin
            ar_valid = 1;
            #1;
            chk({tag, " stall ar_ready"}, 64'(ar_ready), 64'(0));
            tick();
            check_resp(v, {tag, " held"});
        end
        ar_valid = 0;
        r_ready = 1; b_ready = 1;
        tick();
        r_ready = 0; b_ready = 0;
        chk({tag, " valid after hs"}, 64'(r_valid | b_valid), 64'(0));
    endtask

    vec_t vecs[7];
    vec_t rv;
    bit   exp_wr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 0; ar_valid = 0; aw_valid = 0; w_valid = 0; r_ready = 0; b_ready = 0;
        ar_id = 0; aw_id = 0; ar_addr = 0; aw_addr = 0; ar_user = 0; aw_user = 0; w_user = 0;
        w_data = 0; w_strb = 0; reg_ack = 0; reg_rdata = 0; reg_err = 0;

        //                 wr addr    data          strb id u dly err rdata        hold
        vecs[0] = '{0, 12'h014, 32'h0,        4'h0, 1, 0, 0,  0, 32'hDEADBEEF, 0,
                    12'h014, 4'hF, 2'b00, 32'hDEADBEEF, 1};
        vecs[1] = '{1, 12'h0FE, 32'h12345678, 4'h3, 1, 1, 1,  1, 32'h0,        1,
                    12'h0FC, 4'h3, 2'b10, 32'h0,        2};
        vecs[2] = '{0, 12'h7FF, 32'h0,        4'h0, 0, 1, 3,  1, 32'h000055AA, 0,
                    12'h7FC, 4'hF, 2'b10, 32'h000055AA, 4};
        vecs[3] = '{0, 12'h100, 32'h0,        4'h0, 1, 0, 4,  0, 32'hCAFEF00D, 0,
                    12'h100, 4'hF, 2'b00, 32'hCAFEF00D, 5};
        vecs[4] = '{0, 12'h200, 32'h0,        4'h0, 1, 1, 99, 0, 32'h11111111, 10,
                    12'h200, 4'hF, 2'b11, 32'h0,        5};
        vecs[5] = '{1, 12'h003, 32'hA5A5A5A5, 4'h0, 0, 0, 2,  0, 32'h0,        0,
                    12'h000, 4'h0, 2'b00, 32'h0,        3};
        vecs[6] = '{1, 12'hABC, 32'h0BADF00D, 4'hF, 1, 0, 99, 1, 32'h0,        2,
                    12'hABC, 4'hF, 2'b11, 32'h0,        5};

        repeat (3) tick();
        chk("rst reg_req", 64'(reg_req), 64'(0));
        chk("rst reg_we", 64'(reg_we), 64'(0));
        chk("rst readies", 64'({ar_ready, aw_ready, w_ready}), 64'(0));
        chk("rst valids", 64'({r_valid, b_valid}), 64'(0));
        chk("rst payload", 64'({reg_addr, reg_be, r_data, r_resp, r_id, b_resp}), 64'(0));
        rstn = 1;

        // Both candidates pending continuously: service must alternate, read first.
        for (int i = 0; i < 4; i++) begin
            ar_valid = 1; aw_valid = 1; w_valid = 1;
            ar_addr = 12'h040; aw_addr = 12'h080; w_data = 32'h1; w_strb = 4'hF;
            exp_wr = (i % 2 == 1);
            #1;
            chk("prio ar_ready", 64'(ar_ready), 64'(!exp_wr));
            chk("prio aw_ready", 64'(aw_ready & w_ready), 64'(exp_wr));
            tick();
            ar_valid = 0; aw_valid = 0; w_valid = 0;
            chk("prio reg_we", 64'(reg_we), 64'(exp_wr));
            reg_ack = 1; reg_err = 0; reg_rdata = 32'h0;
            tick();
            reg_ack = 0;
            chk("prio resp valid", 64'({r_valid, b_valid}), 64'(exp_wr ? 2'b01 : 2'b10));
            r_ready = 1; b_ready = 1;
            tick();
            r_ready = 0; b_ready = 0;
        end

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while a read is waiting on the register bus.
        ar_valid = 1; ar_addr = 12'h040; ar_id = 1; ar_user = 1;
        #1;
        tick();
        ar_valid = 0;
        chk("midrst req before", 64'(reg_req), 64'(1));
        rstn = 0;
        tick();
        chk("midrst reg_req", 64'(reg_req), 64'(0));
        chk("midrst outputs", 64'({reg_we, reg_addr, reg_be, r_valid, r_id, r_user, r_resp}), 64'(0));
        rstn = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst no r_valid", 64'({r_valid, reg_req}), 64'(0));
        end
        run_txn(vecs[0], "post-reset read");

        for (int n = 0; n < 40; n++) begin
            rv.wr    = bit'($urandom_range(0, 1));
            rv.addr  = 12'($urandom());
            rv.data  = $urandom();
            rv.strb  = 4'($urandom());
            rv.id    = 1'($urandom());
            rv.user  = 1'($urandom());
            rv.dly   = int'($urandom_range(0, 6));
            rv.err   = bit'($urandom_range(0, 1));
            rv.rdata = $urandom();
            rv.hold  = int'($urandom_range(0, 2));
            run_txn(model(rv), $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
